// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Purpose  : Scan controller for the 8-register, 8-digit seven-segment
//            display. Splits time into four phases, each beginning with a
//            blanking gap that prevents ghosting. Drives the active-low group
//            select and presents the even/odd register pair of the current
//            phase from a snapshot taken once per frame.
// Ports    : clk         - system clock
//            rst_n       - synchronous active-low reset
//            en          - 1 = scan, 0 = dark and scan state cleared
//            hold        - 1 = keep the old snapshot at frame start
//            regs_in     - eight 16-bit registers, reg k at [16k+15:16k]
//            sel_out     - active-low group select (4'b1111 = all off)
//            pair_lo     - snapshot of the even register for this phase
//            pair_hi     - snapshot of the odd register for this phase
//            blank       - 1 while every select is off
//            phase       - current phase index
//            frame_start - 1-cycle pulse at the start of phase 0
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
  parameter int unsigned PRESCALE = 8000,  // clk cycles per phase, 4..65535
  parameter int unsigned BLANK    = 64     // blank cycles, 1 <= BLANK < PRESCALE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         hold,
  input  logic [127:0] regs_in,
  output logic [3:0]   sel_out,
  output logic [15:0]  pair_lo,
  output logic [15:0]  pair_hi,
  output logic         blank,
  output logic [1:0]   phase,
  output logic         frame_start
);

  localparam logic [15:0] C_CNT_MAX = 16'(PRESCALE - 1);
  localparam logic [15:0] C_BLANK   = 16'(BLANK);
  localparam logic [1:0]  C_PHASE_LAST = 2'd3;

  // Scan state: a single bit distinguishes idle from running.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [1:0]  r_phase;
  logic [15:0] r_cnt;
  logic [15:0] r_shadow [8];

  logic        w_running;
  logic        w_phase_end;
  logic        w_frame_entry;
  logic        w_blank;

  assign w_running   = (r_state == S_RUN);
  assign w_phase_end = (r_cnt == C_CNT_MAX);

  // True on the edge that lands the scan on (run, phase 0, cnt 0): either
  // entry from idle or wrap out of the last phase. Disabling takes priority.
  assign w_frame_entry = en && (!w_running ||
                                (w_phase_end && (r_phase == C_PHASE_LAST)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= 2'd0;
      r_cnt   <= 16'd0;
    end else if (!en) begin
      // Abort without finishing the current phase.
      r_state <= S_IDLE;
      r_phase <= 2'd0;
      r_cnt   <= 16'd0;
    end else if (!w_running) begin
      r_state <= S_RUN;
      r_phase <= 2'd0;
      r_cnt   <= 16'd0;
    end else if (w_phase_end) begin
      r_cnt   <= 16'd0;
      r_phase <= r_phase + 2'd1;
    end else begin
      r_cnt   <= r_cnt + 16'd1;
    end
  end

  // Frame-coherent snapshot: register inputs are only sampled on frame entry,
  // so mid-frame CPU writes never tear the displayed frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        r_shadow[k] <= 16'd0;
      end
    end else if (w_frame_entry && !hold) begin
      for (int k = 0; k < 8; k++) begin
        r_shadow[k] <= regs_in[16*k +: 16];
      end
    end
  end

  // Outputs are pure decodes of registered state.
  assign w_blank = !w_running || (r_cnt < C_BLANK);

  always_comb begin
    sel_out = 4'b1111;
    if (!w_blank) begin
      sel_out = ~(4'b1000 >> r_phase);
    end
  end

  assign blank       = w_blank;
  assign phase       = r_phase;
  assign pair_lo     = r_shadow[{r_phase, 1'b0}];
  assign pair_hi     = r_shadow[{r_phase, 1'b1}];
  assign frame_start = w_running && (r_phase == 2'd0) && (r_cnt == 16'd0);

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan_ctrl
// Purpose  : Directed self-checking bench for disp_scan_ctrl with
//            PRESCALE=8, BLANK=2 (frame = 32 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan_ctrl;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         hold;
  logic [127:0] regs_in;
  logic [3:0]   sel_out;
  logic [15:0]  pair_lo;
  logic [15:0]  pair_hi;
  logic         blank;
  logic [1:0]   phase;
  logic         frame_start;

  int n_pass  = 0;
  int n_total = 0;

  disp_scan_ctrl #(.PRESCALE(8), .BLANK(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .hold        (hold),
    .regs_in     (regs_in),
    .sel_out     (sel_out),
    .pair_lo     (pair_lo),
    .pair_hi     (pair_hi),
    .blank       (blank),
    .phase       (phase),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle; inputs changed here apply at the next edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // reg k = 16'h1000*k + k
  task automatic set_pattern();
    for (int k = 0; k < 8; k++) begin
      regs_in[16*k +: 16] = 16'(4097 * k);
    end
  endtask

  // Reset, then enable; returns at frame cycle t=0 (run, phase 0, cnt 0).
  task automatic start_scan();
    rst_n = 1'b0;
    en    = 1'b0;
    step(1);
    rst_n = 1'b1;
    en    = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    hold    = 1'b0;
    regs_in = {8{16'hFFFF}};
    step(2);
    n_total++; if (sel_out !== 4'b1111) $display("FAIL reset_sel got %b want 1111", sel_out); else n_pass++;
    n_total++; if (blank !== 1'b1) $display("FAIL reset_blank got %b want 1", blank); else n_pass++;
    n_total++; if (phase !== 2'd0) $display("FAIL reset_phase got %0d want 0", phase); else n_pass++;
    n_total++; if (frame_start !== 1'b0) $display("FAIL reset_fs got %b want 0", frame_start); else n_pass++;
    n_total++; if (pair_lo !== 16'h0) $display("FAIL reset_pair_lo got %h want 0000", pair_lo); else n_pass++;
    n_total++; if (pair_hi !== 16'h0) $display("FAIL reset_pair_hi got %h want 0000", pair_hi); else n_pass++;
  endtask

  // Two full frames of select/blank/phase/frame_start/pair decoding.
  task automatic test_scan();
    logic [1:0]  p;
    logic [2:0]  c;
    logic        eb;
    logic [3:0]  es;
    logic [15:0] elo;
    logic [15:0] ehi;
    set_pattern();
    start_scan();
    for (int t = 0; t < 64; t++) begin
      p   = 2'((t / 8) % 4);
      c   = 3'(t % 8);
      eb  = (c < 3'd2);
      case (p)
        2'd0: es = 4'b0111;
        2'd1: es = 4'b1011;
        2'd2: es = 4'b1101;
        default: es = 4'b1110;
      endcase
      if (eb) es = 4'b1111;
      elo = 16'(4097 * (2 * int'(p)));
      ehi = 16'(4097 * (2 * int'(p) + 1));
      n_total++; if (sel_out !== es) $display("FAIL scan_sel t=%0d got %b want %b", t, sel_out, es); else n_pass++;
      n_total++; if (blank !== eb) $display("FAIL scan_blank t=%0d got %b want %b", t, blank, eb); else n_pass++;
      n_total++; if (phase !== p) $display("FAIL scan_phase t=%0d got %0d want %0d", t, phase, p); else n_pass++;
      n_total++; if (frame_start !== (t % 32 == 0)) $display("FAIL scan_fs t=%0d got %b want %b", t, frame_start, (t % 32 == 0)); else n_pass++;
      n_total++; if (pair_lo !== elo) $display("FAIL scan_pair_lo t=%0d got %h want %h", t, pair_lo, elo); else n_pass++;
      n_total++; if (pair_hi !== ehi) $display("FAIL scan_pair_hi t=%0d got %h want %h", t, pair_hi, ehi); else n_pass++;
      step(1);
    end
  endtask

  // Mid-frame register writes are invisible until the next frame start.
  task automatic test_snapshot();
    set_pattern();
    regs_in[15:0] = 16'h1234;
    start_scan();                                   // t=0
    n_total++; if (pair_lo !== 16'h1234) $display("FAIL snap_initial got %h want 1234", pair_lo); else n_pass++;
    step(3);                                        // t=3
    regs_in[15:0] = 16'h5555;
    step(1);                                        // t=4
    n_total++; if (pair_lo !== 16'h1234) $display("FAIL snap_midphase got %h want 1234", pair_lo); else n_pass++;
    step(15);                                       // t=19, phase 2 cnt 3
    regs_in[15:0] = 16'hABCD;
    step(13);                                       // t=32, new frame
    n_total++; if (frame_start !== 1'b1) $display("FAIL snap_fs got %b want 1", frame_start); else n_pass++;
    n_total++; if (pair_lo !== 16'hABCD) $display("FAIL snap_newframe got %h want abcd", pair_lo); else n_pass++;
  endtask

  // hold=1 across a frame start keeps the old snapshot.
  task automatic test_hold();
    set_pattern();
    hold = 1'b0;
    start_scan();
    step(16);                                       // t=16, phase 2
    n_total++; if (pair_hi !== 16'h5005) $display("FAIL hold_before got %h want 5005", pair_hi); else n_pass++;
    step(4);                                        // t=20
    regs_in[5*16 +: 16] = 16'hBEEF;
    hold = 1'b1;
    step(12);                                       // t=32
    n_total++; if (frame_start !== 1'b1) $display("FAIL hold_fs got %b want 1", frame_start); else n_pass++;
    step(16);                                       // t=48, phase 2
    n_total++; if (pair_hi !== 16'h5005) $display("FAIL hold_frozen got %h want 5005", pair_hi); else n_pass++;
    hold = 1'b0;
    step(32);                                       // t=80, phase 2
    n_total++; if (pair_hi !== 16'hBEEF) $display("FAIL hold_release got %h want beef", pair_hi); else n_pass++;
  endtask

  // en=0 mid-phase aborts; re-enable restarts a fresh frame with a new snapshot.
  task automatic test_enable_abort();
    set_pattern();
    start_scan();
    step(21);                                       // t=21, phase 2 cnt 5
    n_total++; if (sel_out !== 4'b1101) $display("FAIL abort_lit got %b want 1101", sel_out); else n_pass++;
    en = 1'b0;
    step(1);
    n_total++; if (sel_out !== 4'b1111) $display("FAIL abort_sel got %b want 1111", sel_out); else n_pass++;
    n_total++; if (blank !== 1'b1) $display("FAIL abort_blank got %b want 1", blank); else n_pass++;
    n_total++; if (phase !== 2'd0) $display("FAIL abort_phase got %0d want 0", phase); else n_pass++;
    n_total++; if (frame_start !== 1'b0) $display("FAIL abort_fs got %b want 0", frame_start); else n_pass++;
    step(3);
    n_total++; if (sel_out !== 4'b1111) $display("FAIL idle_sel got %b want 1111", sel_out); else n_pass++;
    regs_in[15:0] = 16'h7777;
    en = 1'b1;
    step(1);
    n_total++; if (frame_start !== 1'b1) $display("FAIL reen_fs got %b want 1", frame_start); else n_pass++;
    n_total++; if (pair_lo !== 16'h7777) $display("FAIL reen_snap got %h want 7777", pair_lo); else n_pass++;
    n_total++; if (blank !== 1'b1) $display("FAIL reen_blank got %b want 1", blank); else n_pass++;
    step(2);                                        // cnt 2, first lit cycle
    n_total++; if (sel_out !== 4'b0111) $display("FAIL reen_lit got %b want 0111", sel_out); else n_pass++;
    n_total++; if (frame_start !== 1'b0) $display("FAIL reen_fs_off got %b want 0", frame_start); else n_pass++;
  endtask

  // Reset mid phase 3 with en held high clears everything including shadows.
  task automatic test_reset_midscan();
    set_pattern();
    start_scan();
    step(26);                                       // t=26, phase 3 cnt 2
    n_total++; if (sel_out !== 4'b1110) $display("FAIL rst_mid_lit got %b want 1110", sel_out); else n_pass++;
    rst_n = 1'b0;
    step(1);
    n_total++; if (sel_out !== 4'b1111) $display("FAIL rst_mid_sel got %b want 1111", sel_out); else n_pass++;
    n_total++; if (blank !== 1'b1) $display("FAIL rst_mid_blank got %b want 1", blank); else n_pass++;
    n_total++; if (phase !== 2'd0) $display("FAIL rst_mid_phase got %0d want 0", phase); else n_pass++;
    n_total++; if (frame_start !== 1'b0) $display("FAIL rst_mid_fs got %b want 0", frame_start); else n_pass++;
    n_total++; if (pair_lo !== 16'h0) $display("FAIL rst_mid_lo got %h want 0000", pair_lo); else n_pass++;
    n_total++; if (pair_hi !== 16'h0) $display("FAIL rst_mid_hi got %h want 0000", pair_hi); else n_pass++;
    rst_n = 1'b1;
    step(1);
    n_total++; if (frame_start !== 1'b1) $display("FAIL rst_restart_fs got %b want 1", frame_start); else n_pass++;
    n_total++; if (pair_hi !== 16'h1001) $display("FAIL rst_restart_hi got %h want 1001", pair_hi); else n_pass++;
    step(10);                                       // phase 1 cnt 2
    n_total++; if (phase !== 2'd1) $display("FAIL rst_restart_phase got %0d want 1", phase); else n_pass++;
    n_total++; if (sel_out !== 4'b1011) $display("FAIL rst_restart_sel got %b want 1011", sel_out); else n_pass++;
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    hold    = 1'b0;
    regs_in = '0;
    test_reset();
    test_scan();
    test_snapshot();
    test_hold();
    test_enable_abort();
    test_reset_midscan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
